// File: rtl/matrix_pkg.sv
// Shared types and constants for the 16x8 RGB matrix transmit/receive paths.
package matrix_pkg;
  typedef enum logic [1:0] {WAIT_FRAME, RECEIVE, FRAME_DONE} rx_state_t;

  localparam int MATRIX_COLUMNS           = 16;
  localparam int MATRIX_ROWS              = 8;
  localparam int MATRIX_COLORS            = 3;
  localparam int COL_W                    = $clog2(MATRIX_COLUMNS);
  localparam int DEFAULT_SPI_SIZE         = 8;
  localparam int DEFAULT_BYTES_PER_MATRIX = MATRIX_ROWS * MATRIX_COLUMNS * MATRIX_COLORS;
endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for a group of asynchronous nets, with rise/fall detect.
module sync_edge_detect
  import matrix_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);
  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      sync <= '0;
      prev <= '0;
    end else begin
      meta <= d;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;
  assign fall = ~sync & prev;
endmodule

// File: rtl/matrix_stream_receiver.sv
// Rebuilds per-lane SPI words from oversampled matrix lines and tracks
// frame position (byte index) and latched column.
module matrix_stream_receiver
  import matrix_pkg::*;
#(
  parameter int CHANNEL_NUMBER   = 3,
  parameter int SPI_SIZE         = DEFAULT_SPI_SIZE,
  parameter int BYTES_PER_MATRIX = DEFAULT_BYTES_PER_MATRIX,
  parameter int TIMEOUT_CYCLES   = 1024,
  localparam int IDX_W  = $clog2(BYTES_PER_MATRIX + 1),
  localparam int BIT_W  = $clog2(SPI_SIZE),
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               spi_clk,
  input  logic [CHANNEL_NUMBER-1:0]          spi_mosi,
  input  logic                               ser_clk,
  input  logic                               ser_data,
  input  logic                               ser_stcp,
  input  logic                               ser_n_enable,
  output logic [CHANNEL_NUMBER*SPI_SIZE-1:0] data_out,
  output logic                               data_valid,
  output logic [IDX_W-1:0]                   byte_index,
  output logic [COL_W-1:0]                   column_index,
  output logic                               frame_start,
  output logic                               frame_done,
  output logic                               blanked,
  output logic                               err_overrun,
  output logic                               err_partial
);
  logic [CHANNEL_NUMBER:0] spi_sync, spi_rise, spi_fall;
  logic [3:0]              ser_sync, ser_rise, ser_fall;

  // MOSI shares the spi_clk synchronizer so each lane bit lines up with its edge.
  sync_edge_detect #(.WIDTH(CHANNEL_NUMBER + 1)) u_spi_sync (
    .clk (clk),
    .rst (rst),
    .d   ({spi_mosi, spi_clk}),
    .sync(spi_sync),
    .rise(spi_rise),
    .fall(spi_fall)
  );

  sync_edge_detect #(.WIDTH(4)) u_ser_sync (
    .clk (clk),
    .rst (rst),
    .d   ({ser_n_enable, ser_stcp, ser_data, ser_clk}),
    .sync(ser_sync),
    .rise(ser_rise),
    .fall(ser_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{spi_rise[CHANNEL_NUMBER:1], spi_fall[CHANNEL_NUMBER:1],
                          ser_sync[2], ser_sync[0], ser_rise[3], ser_rise[1], ser_fall};

  logic [CHANNEL_NUMBER-1:0] mosi;
  logic spi_edge, img_evt, col_step, stcp_evt;
  assign mosi     = spi_sync[CHANNEL_NUMBER:1];
  assign spi_edge = spi_rise[0] | spi_fall[0];
  assign img_evt  = ser_rise[0] & ser_sync[1];
  assign col_step = ser_rise[0] & ~ser_sync[1];
  assign stcp_evt = ser_rise[2];
  assign blanked  = ser_sync[3];

  logic [CHANNEL_NUMBER-1:0][SPI_SIZE-1:0] shift_p0, word_next;
  logic [CHANNEL_NUMBER*SPI_SIZE-1:0]      word_p0;
  logic                                    vld_p0, img_p0;
  logic [BIT_W-1:0]                        bit_cnt;
  logic [IDLE_W-1:0]                       idle_cnt;
  logic [COL_W-1:0]                        pend_col;

  always_comb begin
    word_next = shift_p0;
    for (int c = 0; c < CHANNEL_NUMBER; c++) begin
      word_next[c] = {shift_p0[c][SPI_SIZE-2:0], mosi[c]};
    end
  end

  // ---- stage p0: word assembly, timeout and column tracking ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_p0     <= '0;
      word_p0      <= '0;
      vld_p0       <= 1'b0;
      img_p0       <= 1'b0;
      bit_cnt      <= '0;
      idle_cnt     <= '0;
      err_partial  <= 1'b0;
      pend_col     <= '0;
      column_index <= '0;
    end else begin
      vld_p0      <= 1'b0;
      img_p0      <= img_evt;
      err_partial <= 1'b0;

      if (spi_edge)
        idle_cnt <= '0;
      else if (idle_cnt != IDLE_W'(TIMEOUT_CYCLES))
        idle_cnt <= idle_cnt + 1'b1;

      if (spi_rise[0]) begin
        shift_p0 <= word_next;
        if (bit_cnt == BIT_W'(SPI_SIZE - 1)) begin
          word_p0 <= word_next;
          vld_p0  <= 1'b1;
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES) && bit_cnt != '0) begin
        bit_cnt     <= '0;
        err_partial <= 1'b1;
      end

      // A completed word above is still handed on; only partial state is wiped.
      if (img_evt) begin
        bit_cnt  <= '0;
        shift_p0 <= '0;
        pend_col <= '0;
      end else if (col_step) begin
        pend_col <= (pend_col == COL_W'(MATRIX_COLUMNS - 1)) ? '0 : pend_col + 1'b1;
      end

      if (stcp_evt)
        column_index <= pend_col;
    end
  end

  rx_state_t        state_q, state_d;
  logic             emit, last_word, ovr_set;
  logic [IDX_W-1:0] word_cnt;

  always_comb begin
    state_d   = state_q;
    emit      = 1'b0;
    last_word = 1'b0;
    ovr_set   = 1'b0;
    if (vld_p0) begin
      case (state_q)
        RECEIVE: begin
          emit = 1'b1;
          if (word_cnt == IDX_W'(BYTES_PER_MATRIX - 1)) begin
            last_word = 1'b1;
            state_d   = FRAME_DONE;
          end
        end
        FRAME_DONE: ovr_set = 1'b1;
        default: ;
      endcase
    end
    if (img_p0)
      state_d = RECEIVE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= WAIT_FRAME;
    else     state_q <= state_d;
  end

  // ---- stage p1: frame sequencing and outputs ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt    <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      byte_index  <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      data_valid  <= emit;
      frame_done  <= last_word;
      frame_start <= img_p0;
      if (emit) begin
        data_out   <= word_p0;
        byte_index <= word_cnt;
        word_cnt   <= last_word ? '0 : word_cnt + 1'b1;
      end
      if (ovr_set)
        err_overrun <= 1'b1;
      if (img_p0) begin
        word_cnt    <= '0;
        err_overrun <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_matrix_stream_receiver.sv
// Directed/randomized bench for matrix_stream_receiver against a frame-level model.
module tb_matrix_stream_receiver;
  localparam int CH  = 3;
  localparam int SZ  = 8;
  localparam int BPM = 384;
  localparam int TO  = 1024;
  localparam int IW  = $clog2(BPM + 1);
  localparam int DW  = CH * SZ;

  logic          clk = 1'b0, rst = 1'b1;
  logic          spi_clk = 1'b0;
  logic [CH-1:0] spi_mosi = '0;
  logic          ser_clk = 1'b0, ser_data = 1'b0, ser_stcp = 1'b0, ser_n_enable = 1'b0;
  logic [DW-1:0] data_out;
  logic          data_valid, frame_start, frame_done, blanked, err_overrun, err_partial;
  logic [IW-1:0] byte_index;
  logic [3:0]    column_index;

  matrix_stream_receiver #(
    .CHANNEL_NUMBER(CH), .SPI_SIZE(SZ), .BYTES_PER_MATRIX(BPM), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .ser_clk(ser_clk), .ser_data(ser_data), .ser_stcp(ser_stcp), .ser_n_enable(ser_n_enable),
    .data_out(data_out), .data_valid(data_valid), .byte_index(byte_index),
    .column_index(column_index), .frame_start(frame_start), .frame_done(frame_done),
    .blanked(blanked), .err_overrun(err_overrun), .err_partial(err_partial)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
    logic [IW-1:0] i;
    logic          fd;
  } word_t;

  word_t act_q[$], exp_q[$];
  int    act_cyc[$], exp_cyc[$];
  int    cyc = 0, fs_cnt = 0, ep_cnt = 0;
  int    checks = 0, errors = 0;

  // Frame-level reference model
  bit in_frame = 0, fdone = 0, ovr = 0;
  int idx = 0, exp_fs = 0, exp_ep = 0, pend = 0, rise_cyc = 0;

  logic [63:0] all_outs;
  assign all_outs = 64'({data_out, data_valid, byte_index, column_index, frame_start,
                         frame_done, blanked, err_overrun, err_partial});

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (data_valid || frame_done) begin
      act_q.push_back('{data_valid, data_out, byte_index, frame_done});
      act_cyc.push_back(cyc);
    end
    if (frame_start) fs_cnt = fs_cnt + 1;
    if (err_partial) ep_cnt = ep_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    in_frame = 0; fdone = 0; ovr = 0; idx = 0; pend = 0;
  endtask

  task automatic model_marker();
    in_frame = 1; fdone = 0; ovr = 0; idx = 0; pend = 0;
    exp_fs++;
  endtask

  task automatic model_word(input logic [DW-1:0] w);
    if (in_frame && !fdone) begin
      exp_q.push_back('{1'b1, w, IW'(idx), (idx == BPM - 1)});
      exp_cyc.push_back(rise_cyc + 3);
      idx++;
      if (idx == BPM) fdone = 1;
    end else if (in_frame) begin
      ovr = 1;
    end
  endtask

  task automatic send_bit(input logic [CH-1:0] b, input bit mark);
    @(negedge clk) spi_mosi = b;
    @(negedge clk) begin
      spi_clk = 1'b1;
      if (mark) ser_clk = 1'b1;
      rise_cyc = cyc + 1;
    end
    @(negedge clk);
    @(negedge clk) begin
      spi_clk = 1'b0;
      ser_clk = 1'b0;
    end
  endtask

  task automatic send_word(input logic [DW-1:0] w, input bit mark);
    logic [CH-1:0] b;
    if (mark) @(negedge clk) ser_data = 1'b1;
    for (int i = SZ - 1; i >= 0; i--) begin
      for (int c = 0; c < CH; c++) b[c] = w[c*SZ + i];
      send_bit(b, mark && (i == 0));
    end
    if (mark) @(negedge clk) ser_data = 1'b0;
    model_word(w);
    if (mark) model_marker();
  endtask

  task automatic marker();
    @(negedge clk) ser_data = 1'b1;
    @(negedge clk) ser_clk = 1'b1;
    @(negedge clk);
    @(negedge clk) ser_clk = 1'b0;
    @(negedge clk) ser_data = 1'b0;
    model_marker();
  endtask

  task automatic col_pulse();
    @(negedge clk) ser_clk = 1'b1;
    @(negedge clk);
    @(negedge clk) ser_clk = 1'b0;
    @(negedge clk);
    pend = (pend + 1) % 16;
  endtask

  task automatic stcp_pulse();
    @(negedge clk) ser_stcp = 1'b1;
    @(negedge clk);
    @(negedge clk) ser_stcp = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_words(input string tag);
    word_t a, e;
    int    lat;
    repeat (8) @(negedge clk);
    chk({tag, "_count"}, 64'(act_q.size()), 64'(exp_q.size()));
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a   = act_q.pop_front();
      e   = exp_q.pop_front();
      lat = act_cyc.pop_front() - exp_cyc.pop_front();
      chk({tag, "_word"}, 64'(a), 64'(e));
      chk({tag, "_latency_ok"}, 64'(lat == 0 || lat == 1), 64'd1);
    end
    act_q.delete(); exp_q.delete(); act_cyc.delete(); exp_cyc.delete();
    chk({tag, "_frame_start"}, 64'(fs_cnt), 64'(exp_fs));
    chk({tag, "_err_partial"}, 64'(ep_cnt), 64'(exp_ep));
    chk({tag, "_err_overrun"}, 64'(err_overrun), 64'(ovr));
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    chk(tag, all_outs, 64'd0);
    @(negedge clk) rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [DW-1:0] w;

    // Power-on reset
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs, 64'd0);
    @(negedge clk) rst = 1'b0;
    check_words("idle_after_reset");

    // Words before any marker are dropped
    for (int k = 0; k < 5; k++) send_word(DW'($urandom), 1'b0);
    check_words("pre_marker");
    marker();
    w = DW'($urandom);
    w[7:0] = 8'hA5;
    send_word(w, 1'b0);
    check_words("first_after_marker");
    chk("lane0_a5", 64'(data_out[7:0]), 64'hA5);

    // Reset then one full frame of fixed lane patterns
    pulse_reset("reset_pulse_outputs");
    marker();
    for (int k = 0; k < BPM; k++) send_word({8'h0F, 8'hFF, 8'h01}, 1'b0);
    check_words("full_frame");

    // Overrun: 385 random words after a marker
    marker();
    for (int k = 0; k < BPM; k++) send_word(DW'($urandom), 1'b0);
    check_words("overrun_384");
    send_word(DW'($urandom), 1'b0);
    check_words("overrun_385");
    marker();
    check_words("overrun_cleared");

    // Partial word discarded by timeout
    for (int k = 0; k < 3; k++) send_bit(CH'($urandom), 1'b0);
    repeat (TO + 30) @(negedge clk);
    exp_ep++;
    check_words("partial_timeout");
    send_word({3{8'h3C}}, 1'b0);
    check_words("after_timeout");

    // Column tracking with wrap, plus blanking follow-through
    marker();
    stcp_pulse();
    chk("column_after_marker", 64'(column_index), 64'(pend));
    for (int k = 0; k < 17; k++) begin
      col_pulse();
      stcp_pulse();
      chk("column_step", 64'(column_index), 64'(pend));
    end
    check_words("columns");
    @(negedge clk) ser_n_enable = 1'b1;
    repeat (4) @(negedge clk);
    chk("blanked_high", 64'(blanked), 64'd1);
    @(negedge clk) ser_n_enable = 1'b0;
    repeat (4) @(negedge clk);
    chk("blanked_low", 64'(blanked), 64'd0);

    // Marker coincident with a word event
    send_word(DW'($urandom), 1'b0);
    send_word(DW'($urandom), 1'b0);
    send_word(DW'($urandom), 1'b1);
    send_word(DW'($urandom), 1'b0);
    check_words("simultaneous");

    // Reset in the middle of a word
    for (int k = 0; k < 4; k++) send_bit(CH'($urandom), 1'b0);
    pulse_reset("midword_reset_outputs");
    repeat (20) @(negedge clk);
    chk("after_reset_outputs", all_outs, 64'd0);
    check_words("after_midword_reset");
    marker();
    send_word(DW'($urandom), 1'b0);
    check_words("frame_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/matrix_stream_receiver.md
# matrix_stream_receiver

Receive-side counterpart to the matrix output path. It samples the multi-channel SPI lines (`spi_clk`, `spi_mosi[]`) and the column shift-register lines (`ser_clk`, `ser_data`, `ser_stcp`, `ser_n_enable`) as produced for the 16x8 RGB matrices, and rebuilds per-channel bytes with frame and column positions. It is used as a loopback checker on the FPGA and as the front end of a matrix-emulating receiver. All inputs are asynchronous to `clk` and are oversampled.

## Interface
- `CHANNEL_NUMBER`, 3: number of parallel MOSI lanes.
- `SPI_SIZE`, 8: bits per word, MSB first.
- `BYTES_PER_MATRIX`, 384: words per lane per frame (8*16*3).
- `TIMEOUT_CYCLES`, 1024: `clk` cycles of `spi_clk` inactivity after which a partial word is discarded.
- `clk` in 1: oversampling clock; must be at least 4x the `spi_clk` frequency.
- `rst` in 1: reset, asynchronous, active-high. Clock is `clk`.
- `spi_clk` in 1: SPI clock, idle low, data valid on the rising edge.
- `spi_mosi` in CHANNEL_NUMBER: one data lane per channel.
- `ser_clk` in 1: shift-register clock.
- `ser_data` in 1: shift-register data; 1 marks column 0 (new image).
- `ser_stcp` in 1: shift-register storage latch.
- `ser_n_enable` in 1: active-low output enable of the shift register.
- `data_out` out CHANNEL_NUMBER x SPI_SIZE: last completed word of each lane.
- `data_valid` out 1: one-cycle pulse when `data_out` updates.
- `byte_index` out $clog2(BYTES_PER_MATRIX+1): index of the word on `data_out`.
- `column_index` out 4: latched column, 0..15.
- `frame_start` out 1: one-cycle pulse on a new-image marker.
- `frame_done` out 1: one-cycle pulse when word BYTES_PER_MATRIX-1 is emitted.
- `blanked` out 1: synchronized copy of `ser_n_enable`.
- `err_overrun` out 1: sticky flag for a word received in FRAME_DONE; cleared on `frame_start`.
- `err_partial` out 1: one-cycle pulse when a timeout discards bits.

## Operation
- **Synchronizers:** all six input nets pass through 2 flops, then an edge-detect flop. A rising edge is `sync & ~prev`. MOSI uses the same synchronizer depth as `spi_clk`, so lane bits stay aligned with the clock edge.
- **Word assembly:**
  - On each `spi_clk` rising edge, every lane shifts left and takes in its synced MOSI bit. A shared `bit_cnt` counts 0..SPI_SIZE-1.
  - When `bit_cnt` reaches SPI_SIZE-1, the shift registers are copied to `data_out`, `bit_cnt` returns to 0 and a word event is raised.
- **Column tracking:**
  - A `ser_clk` rising edge with `ser_data`=1 raises a new-image event.
  - A `ser_clk` rising edge with `ser_data`=0 increments the pending column, wrapping at 15→0.
  - A `ser_stcp` rising edge copies the pending column to `column_index`.
- **FSM states:** WAIT_FRAME (reset), RECEIVE, FRAME_DONE.
  - **WAIT_FRAME:** word events are dropped, with no `data_valid`. A new-image event goes to RECEIVE.
  - **RECEIVE:** each word event pulses `data_valid` with `byte_index` equal to the counter, then increments the counter. The word at index BYTES_PER_MATRIX-1 also pulses `frame_done` and goes to FRAME_DONE.
  - **FRAME_DONE:** a word event sets `err_overrun`, with no `data_valid`. A new-image event goes to RECEIVE.
  - **Any state:** a new-image event clears the counter, clears `bit_cnt` and the partial bits, pulses `frame_start`, clears `err_overrun` and sets the pending column to 0.
- **Simultaneous word event and new-image event:** the word is emitted first under the old frame's rules and index, then the new-image clear takes effect. The next word gets index 0.
- **Timeout:** an idle counter counts cycles with no `spi_clk` edge. If it reaches TIMEOUT_CYCLES with `bit_cnt`≠0, `bit_cnt` clears and `err_partial` pulses once. The idle counter saturates.
- **Reset values:** every output is 0, state is WAIT_FRAME, all counters and synchronizers are 0. Asserting reset mid-word or mid-frame drops everything in flight, with no pulses.

## Timing
- **Latency:** `data_valid` rises on the 4th `clk` edge after the last raw `spi_clk` rise of a word reaches the first sync flop. The tolerance is +1 cycle for synchronizer uncertainty.
- **Pulse width:** `frame_start` and `frame_done` are one cycle each. `frame_done` is coincident with the final `data_valid`.
- **Counter width:** `byte_index` is $clog2(BYTES_PER_MATRIX+1) bits. Arithmetic is unsigned and never exceeds BYTES_PER_MATRIX-1 in RECEIVE.
- **Input pulse width:** input high and low phases must each last at least 2 `clk` periods. Shorter pulses may be missed and are not detected.

## Structure
- Package `matrix_pkg`:
  - `rx_state_t` enum {WAIT_FRAME, RECEIVE, FRAME_DONE}.
  - `MATRIX_COLUMNS`=16.
  - Default `SPI_SIZE` and `BYTES_PER_MATRIX` constants, shared with the transmit side.
- Sub-module `sync_edge_detect`, parameterized by width. It provides the 2-flop synchronizer plus rise-edge output and is instantiated once per input group.

## Test plan
- **Reset then one frame:** reset, new-image marker, then 384 words per lane (lane0=0x01, lane1=0xFF, lane2=0x0F) → 384 `data_valid` pulses, `byte_index` 0..383, `frame_done` with index 383, no errors.
- **Words before marker:** send 5 words, then a marker, then 1 word with value 0xA5 → 0 pulses from the first 5 words, then one `data_valid` with `byte_index`=0 and `data_out[0]`=0xA5.
- **Overrun:** send 385 words after a marker → `err_overrun`=1 after the 385th word, and it clears on the next `frame_start`.
- **Partial timeout:** send 3 bits, then idle for TIMEOUT_CYCLES → a single `err_partial` pulse. The next full word 0x3C is received intact.
- **Columns and wrap:** marker, then 17 `ser_clk` pulses with `ser_data`=0, each followed by `ser_stcp` → `column_index` runs 0,1..15,0,1.
- **Simultaneous events and reset:** a marker arriving in the same cycle as a word event → the word is emitted with its old index, and the next word has index 0. A `rst` pulse mid-word → all outputs read 0 and no spurious pulses appear.
